cfg_loader: RTL and testbench

Sequences configuration of an array of logic blocks. Each logic block holds a 5-bit configuration register: bits [3:0] are the 4:1 mux data inputs and bit [4] is the 2:1 mux select.
- Accepts a stream of 5-bit configuration words over a valid/ready handshake.
- Writes word k into logic block k with a one-hot write-enable pulse.
- Reports busy/done status to the top-level programming interface.

---
 rtl/cfg_pkg.sv | 20 ++
 rtl/cfg_onehot_dec.sv | 26 ++
 rtl/cfg_loader.sv | 143 ++++++++++++++
 tb/tb_cfg_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and field positions for the logic-block configuration loader.
// No logic of its own; zero latency.
// No flow control here; the handshake lives in cfg_loader.
package cfg_pkg;

  // Configuration word layout of one logic block
  localparam int CFG_W       = 5;
  localparam int CFG_LUT_LSB = 0;
  localparam int CFG_LUT_MSB = 3;
  localparam int CFG_SEL_BIT = 4;

  // ERR is only reachable when the parity check is built in
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/cfg_onehot_dec.sv
// Registered index-to-one-hot decoder driving the per-block write enables.
// Latency: one clock from en/idx to the one-hot output; output is all zeros when en is low.
// No backpressure: an enabled index always produces exactly one pulse.
module cfg_onehot_dec #(
  parameter int NUM_BLOCKS = 16,
  parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [IDX_W-1:0]      idx,
  output logic [NUM_BLOCKS-1:0] onehot
);

  // One pulse per enabled cycle; everything else decodes to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      onehot <= '0;
    end else if (en) begin
      onehot <= NUM_BLOCKS'(1) << idx;
    end else begin
      onehot <= '0;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Streams configuration words into an array of logic blocks, word k into block k.
// Latency: one clock from word accept to the blk_we pulse; done rises with the final pulse.
// Backpressure: cfg_ready is high only in LOAD and is forced low while abort is asserted.
// Optional: define CFG_LOADER_PARITY_EN to add cfg_par/err and the ERR state.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int NUM_BLOCKS = 16,
  parameter int CFG_W      = cfg_pkg::CFG_W,
  parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_valid,
  input  logic [CFG_W-1:0]      cfg_data,
`ifdef CFG_LOADER_PARITY_EN
  input  logic                  cfg_par,
  output logic                  err,
`endif
  output logic                  cfg_ready,
  output logic [NUM_BLOCKS-1:0] blk_we,
  output logic [CFG_W-1:0]      blk_data,
  output logic [IDX_W-1:0]      blk_idx,
  output logic                  busy,
  output logic                  done
);

  cfg_state_t       state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             wr_en;
  logic             last_word;

  assign last_word = (cnt == IDX_W'(NUM_BLOCKS - 1));

`ifdef CFG_LOADER_PARITY_EN
  // Even parity over data plus parity bit must come out zero
  logic par_bad;
  assign par_bad = ^{cfg_data, cfg_par};
`endif

  // State and word counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, handshake and status decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
`ifdef CFG_LOADER_PARITY_EN
    err       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          // Abort wins over a word offered in the same cycle
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
`ifdef CFG_LOADER_PARITY_EN
            if (par_bad) state_nxt = ERR;
            else
`endif
            begin
              wr_en = 1'b1;
              // Counter stops at the last block; no wrap inside a sequence
              if (last_word) state_nxt = DONE;
              else           cnt_nxt   = cnt + 1'b1;
            end
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
`ifdef CFG_LOADER_PARITY_EN
      ERR: begin
        err = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Shared data bus and index hold their last written value between pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_data <= '0;
      blk_idx  <= '0;
    end else if (wr_en) begin
      blk_data <= {cfg_data[CFG_SEL_BIT], cfg_data[CFG_LUT_MSB:CFG_LUT_LSB]};
      blk_idx  <= cnt;
    end
  end

  cfg_onehot_dec #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W)
  ) u_dec (
    .clk    (clk),
    .reset  (reset),
    .en     (wr_en),
    .idx    (cnt),
    .onehot (blk_we)
  );

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboard bench for cfg_loader with a 4-block array.
// Expected write pulses are queued when a word is accepted and checked at the pulse.
// Status and handshake outputs are checked every driven cycle against a small state model.
module tb_cfg_loader;
  import cfg_pkg::*;

  localparam int NB = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [4:0]    cfg_data = '0;
  logic          cfg_par = 1'b0;
  logic          cfg_ready;
  logic [NB-1:0] blk_we;
  logic [4:0]    blk_data;
  logic [IW-1:0] blk_idx;
  logic          busy;
  logic          done;
`ifdef CFG_LOADER_PARITY_EN
  logic          err;
`endif

  cfg_loader #(.NUM_BLOCKS(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
`ifdef CFG_LOADER_PARITY_EN
    .cfg_par   (cfg_par),
    .err       (err),
`endif
    .cfg_ready (cfg_ready),
    .blk_we    (blk_we),
    .blk_data  (blk_data),
    .blk_idx   (blk_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] we;
    logic [4:0]    data;
    logic [IW-1:0] idx;
    logic          last;
    longint        t;
  } exp_t;

  exp_t       sbq[$];
  cfg_state_t m_st = IDLE;
  int         m_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pulse monitor: every non-zero blk_we must match the oldest queued write
  always @(negedge clk) begin
    if (reset && blk_we != '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_we", 64'(blk_we), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("we", 64'(blk_we), 64'(e.we));
        check("data", 64'(blk_data), 64'(e.data));
        check("idx", 64'(blk_idx), 64'(e.idx));
        check("we_time", 64'($time), 64'(e.t + 5));
        check("done_at_pulse", 64'(done), 64'(e.last));
      end
    end
  end

  // One clock of stimulus; status checked before the edge, model advanced at it
  task automatic cyc(input logic v, input logic [4:0] d, input logic p,
                     input logic st, input logic ab);
    logic bad;
    cfg_valid = v; cfg_data = d; cfg_par = p; start = st; abort = ab;
    #1;
    check("cfg_ready", 64'(cfg_ready), 64'((m_st == LOAD) && !ab));
    check("busy", 64'(busy), 64'(m_st == LOAD));
    check("done", 64'(done), 64'(m_st == DONE));
`ifdef CFG_LOADER_PARITY_EN
    check("err", 64'(err), 64'(m_st == ERR));
    bad = ^{d, p};
`else
    bad = 1'b0;
`endif
    @(posedge clk);
    case (m_st)
      IDLE: if (st) begin m_st = LOAD; m_cnt = 0; end
      LOAD: begin
        if (ab) begin
          m_st = IDLE;
        end else if (v) begin
          if (bad) begin
            m_st = ERR;
          end else begin
            exp_t e;
            e.we = NB'(1) << m_cnt;
            e.data = d;
            e.idx = IW'(m_cnt);
            e.last = (m_cnt == NB - 1);
            e.t = longint'($time);
            sbq.push_back(e);
            if (m_cnt == NB - 1) m_st = DONE;
            else m_cnt++;
          end
        end
      end
      default: begin
        if (ab) m_st = IDLE;
        else if (st) begin m_st = LOAD; m_cnt = 0; end
      end
    endcase
    #1;
    cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic send(input logic [4:0] d);
    cyc(1'b1, d, ^d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    cyc(1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drained(input string tag);
    check(tag, 64'(sbq.size()), 64'(0));
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_we"}, 64'(blk_we), 64'(0));
    check({tag, "_data"}, 64'(blk_data), 64'(0));
    check({tag, "_idx"}, 64'(blk_idx), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_ready"}, 64'(cfg_ready), 64'(0));
  endtask

  initial begin
    logic [4:0] words [4];
    words[0] = 5'h01; words[1] = 5'h12; words[2] = 5'h0F; words[3] = 5'h1A;

    // Reset state
    #2;
    all_zero("rst");
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back stream
    go();
    for (int i = 0; i < 4; i++) send(words[i]);
    idle(2);
    drained("t1_drained");
    check("t1_hold_data", 64'(blk_data), 64'(5'h1A));
    check("t1_hold_idx", 64'(blk_idx), 64'(3));

    // 2: stall of three cycles after word 2 (restart from DONE)
    go();
    send(words[0]); send(words[1]);
    idle(3);
    send(words[2]); send(words[3]);
    idle(1);
    drained("t2_drained");

    // 3: abort with a word on offer after two words, then restart
    go();
    send(words[0]); send(words[1]);
    cyc(1'b1, 5'h0F, 1'b0, 1'b0, 1'b1);
    idle(2);
    drained("t3_drained");
    go();
    send(5'h1F);
    idle(1);
    drained("t3_restart");

    // 4: asynchronous reset mid-load
    #2 reset = 1'b0;
    #1 all_zero("t4_async");
    m_st = IDLE; m_cnt = 0; sbq.delete();
    #3 reset = 1'b1;
    idle(3);
    go();
    for (int i = 0; i < 4; i++) send(words[i]);
    idle(1);

    // 5: restart straight from DONE, identical sequence
    go();
    for (int i = 0; i < 4; i++) send(words[i]);
    idle(1);
    drained("t5_drained");

`ifdef CFG_LOADER_PARITY_EN
    // 6: parity error then recovery
    go();
    cyc(1'b1, 5'h03, 1'b1, 1'b0, 1'b0);
    idle(2);
    go();
    cyc(1'b1, 5'h03, 1'b0, 1'b0, 1'b0);
    idle(1);
    drained("t6_drained");
    check("t6_data", 64'(blk_data), 64'(5'h03));
    check("t6_idx", 64'(blk_idx), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
